ram_write_queue: RTL and testbench
==================================

# ram_write_queue

Posting write queue that sits directly upstream of the AXI byte-write stage. It accepts single-cycle byte-write strobes from the core side and buffers them in a FIFO. It then drives the write stage's level-sensitive `en`/`ready` handshake, one byte at a time and in order. Address and data are held stable for the whole downstream transaction, and a `pending` flag lets readers wait until all posted writes have drained.

## Interface

Parameters:

- `ADDR_BITS`, 4: log2 of FIFO depth; DEPTH = 2**ADDR_BITS entries of {addr[20:0], data[7:0]}.

Ports:

- `clk_memory`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `in_we`  in  1  one-cycle push strobe.
- `in_addr`  in  21  byte address to write.
- `in_data`  in  8  byte to write.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_BITS+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a push was dropped.
- `pending`  out  1  high when `~empty` or the sequencer is not IDLE.
- `addr`  out  21  to write stage; registered.
- `data`  out  8  to write stage; registered.
- `en`  out  1  to write stage; registered.
- `ready`  in  1  from write stage.

## Operation

- Reset: FIFO pointers and `count` = 0, `empty`=1, `full`=0, `overflow`=0, `en`=0, `addr`=0, `data`=0, state IDLE, `pending`=0.
- Push: `in_we`=1 and `full`=0 writes {in_addr, in_data} at the write pointer and increments the pointer and `count`.
- Dropped push: `in_we`=1 while `full`=1 drops the entry and sets `overflow`, even if a pop occurs in the same cycle. Only `reset` clears `overflow`.
- Pop: happens only on the IDLE→ISSUE transition. It loads the head into `addr`/`data`, increments the read pointer, and decrements `count`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. `full`/`empty` are derived from `count`.
- Sequencer states:
  - IDLE: `en`=0. If `~empty`, pop, set `en`<=1, go to ISSUE.
  - ISSUE: `en`=1. Wait for `ready`=0, which means the write stage accepted the request, then go to BUSY. The `ready`=1 seen in ISSUE's first cycle is not treated as completion.
  - BUSY: `en`=1, `addr`/`data` frozen. On `ready`=1 (write stage done, waiting for release), set `en`<=0 and go to RELEASE.
  - RELEASE: `en`=0 for exactly one cycle so the write stage samples `~en` and returns to its idle state. Then go to IDLE.
- `addr`/`data` change only at a pop. They stay stable from `en` rise until the next pop.
- Writes issue strictly in FIFO order. There is no coalescing or reordering.
- Integration: the write stage's active-low reset is driven as `~reset`. A reset mid-transaction therefore aborts both blocks together, and queued entries are discarded.

## Timing

- Push-to-issue latency: a push sampled at edge E0 into an empty, IDLE queue gives `empty`=0 after E0 and `en`=1 with valid `addr`/`data` after E1.
- The write stage drops `ready` one cycle after `en` rises. ISSUE→BUSY occurs on the following edge.
- BUSY→RELEASE occurs on the first edge with `ready`=1. `en` is low in the next cycle.
- RELEASE lasts one cycle. IDLE may re-issue on its first cycle, so `en` rises again 2 cycles after it fell. The minimum `en` low time is 2 cycles.
- `ready` held low indefinitely: the block stays in ISSUE or BUSY, `en` stays high, and pushes continue until `full`. There is no timeout.
- `pending` is combinational from `count` and state. It falls in the cycle that IDLE is entered with `empty`=1.

## Test plan

- Reset: assert `reset` for 2 cycles with `in_we`=1 → all outputs at reset values, `count`=0, no `en` pulse.
- Single write: push addr 0x12345, data 0xA5. Use a write-stage model that drops `ready` 1 cycle after `en` rises and raises it 4 cycles later. Expected response:
  - `en` high after E1.
  - `addr`=0x12345 and `data`=0xA5 stable while `en`=1.
  - `en` low 1 cycle after `ready` rises.
  - `pending` low 2 cycles later.
- Fill: 17 back-to-back pushes (data 0x00..0x10) with `ready` stuck low and `ADDR_BITS`=4 → `full`=1 after the 16th push; the 17th is dropped and `overflow`=1. After releasing `ready`, exactly 16 writes occur with data 0x00..0x0F in order.
- Simultaneous push/pop: push on the same cycle as the IDLE→ISSUE pop with `count`=3 → `count` stays 3, and the FIFO order is preserved across pointer wrap (run 40 writes with random gaps, then compare the sequence).
- Release spacing: with the queue non-empty, check that `en` is low for exactly 2 cycles between consecutive writes, and that the model write stage never sees `en` held high across its done state.
- Reset mid-BUSY: assert `reset` while `en`=1 with 5 entries queued → next cycle `en`=0, `count`=0, `overflow`=0. No further writes issue.

Source files
------------

// File: rtl/ram_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ram_write_queue
//  Description : Posting write queue in front of the AXI byte-write stage.
//                Buffers single-cycle byte-write strobes in a FIFO and replays
//                them one at a time, in order, over the write stage's
//                level-sensitive en/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_write_queue #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_memory,
    input  logic                 reset,

    // Core-side push interface
    input  logic                 in_we,
    input  logic [20:0]          in_addr,
    input  logic [7:0]           in_data,

    // Queue status
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 pending,

    // Write-stage handshake
    output logic [20:0]          addr,
    output logic [7:0]           data,
    output logic                 en,
    input  logic                 ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                   c_DEPTH     = 2 ** ADDR_BITS;
    localparam int                   c_ENTRY_W   = 21 + 8;
    localparam logic [ADDR_BITS:0]   c_CNT_DEPTH = (ADDR_BITS + 1)'(c_DEPTH);
    localparam logic [ADDR_BITS:0]   c_CNT_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] c_PTR_ONE   = ADDR_BITS'(1);

    // ------------------------------------------------------------------------
    // Sequencer states
    //   IDLE    : en low, pops the head as soon as the queue is non-empty
    //   ISSUE   : en high, waiting for the write stage to drop ready (accept)
    //   BUSY    : en high, waiting for ready to return (write done)
    //   RELEASE : en low for one cycle so the write stage can return to idle
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [c_ENTRY_W-1:0]   r_mem [c_DEPTH];
    logic [ADDR_BITS-1:0]   r_wr_ptr;
    logic [ADDR_BITS-1:0]   r_rd_ptr;
    logic [ADDR_BITS:0]     r_count;
    logic                   r_overflow;

    // Registered write-stage outputs
    logic [20:0]            r_addr;
    logic [7:0]             r_data;
    logic                   r_en;

    // Combinational control
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic [c_ENTRY_W-1:0]   w_head;

    // Occupancy flags come straight from the counter, so pointer wrap never
    // needs an extra disambiguation bit.
    assign w_full  = (r_count == c_CNT_DEPTH);
    assign w_empty = (r_count == '0);

    // A push is accepted only when there is room as of this cycle; a pop in
    // the same cycle does not make room for it.
    assign w_push  = in_we & ~w_full;
    assign w_drop  = in_we &  w_full;

    assign w_head  = r_mem[r_rd_ptr];

    // Next-state logic for the handshake sequencer; the pop is a side effect
    // of leaving IDLE.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ready is still high on the first ISSUE cycle; only its fall
                // means the write stage has taken the request.
                if (!ready) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ready) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO storage write; contents need no reset because the pointers and
    // count define which entries are live.
    always_ff @(posedge clk_memory) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_addr, in_data};
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop advances
    // both pointers and leaves the count alone.
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky record of any dropped push; only reset clears it.
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Write-stage outputs: addr/data load only at a pop so they stay frozen
    // for the whole transaction; en tracks the states that own the request.
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_en   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= w_head[c_ENTRY_W-1:8];
                r_data <= w_head[7:0];
            end
            r_en <= (w_state_next == S_ISSUE) || (w_state_next == S_BUSY);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    // Readers wait on this until every posted write has fully retired.
    assign pending  = ~w_empty | (r_state != S_IDLE);
    assign addr     = r_addr;
    assign data     = r_data;
    assign en       = r_en;

endmodule
`default_nettype wire

// File: tb/tb_ram_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_write_queue
//  Description : Self-checking bench for ram_write_queue. A queue-based
//                reference model predicts every output each cycle; a model of
//                the downstream write stage drives ready and logs writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_write_queue;

    localparam int ADDR_BITS = 4;
    localparam int DEPTH     = 16;

    logic                 clk_memory = 1'b0;
    logic                 reset      = 1'b1;
    logic                 in_we      = 1'b1;
    logic [20:0]          in_addr    = 21'h1F0F0;
    logic [7:0]           in_data    = 8'h3C;
    logic                 full;
    logic                 empty;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 pending;
    logic [20:0]          addr;
    logic [7:0]           data;
    logic                 en;
    logic                 ready      = 1'b1;

    ram_write_queue #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk_memory (clk_memory),
        .reset      (reset),
        .in_we      (in_we),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .pending    (pending),
        .addr       (addr),
        .data       (data),
        .en         (en),
        .ready      (ready)
    );

    initial forever #5 clk_memory = ~clk_memory;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a queue of posted entries plus the handshake phase of
    // the transaction in flight (0 idle, 1 awaiting accept, 2 awaiting done,
    // 3 release). Updated on every rising edge from the sampled inputs.
    // ------------------------------------------------------------------------
    logic [28:0] m_q[$];
    logic [28:0] m_issued[$];
    int          m_phase   = 0;
    logic        m_en      = 1'b0;
    logic        m_ovf     = 1'b0;
    logic [20:0] m_addr    = '0;
    logic [7:0]  m_data    = '0;
    int          m_accepts = 0;
    int          m_sz;
    logic [28:0] m_e;

    initial forever begin
        @(posedge clk_memory);
        if (reset) begin
            m_q.delete();
            m_issued.delete();
            m_phase = 0;
            m_en    = 1'b0;
            m_ovf   = 1'b0;
            m_addr  = '0;
            m_data  = '0;
        end else begin
            m_sz = m_q.size();
            case (m_phase)
                0: if (m_sz > 0) begin
                    m_e = m_q.pop_front();
                    m_issued.push_back(m_e);
                    m_addr  = m_e[28:8];
                    m_data  = m_e[7:0];
                    m_en    = 1'b1;
                    m_phase = 1;
                end
                1: if (!ready) m_phase = 2;
                2: if (ready) begin
                    m_en    = 1'b0;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
            if (in_we) begin
                if (m_sz == DEPTH) m_ovf = 1'b1;
                else begin
                    m_q.push_back({in_addr, in_data});
                    m_accepts++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk_memory);
        chk("count",    32'(count),    32'(m_q.size()));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("pending",  32'(pending),  32'((m_q.size() != 0) || (m_phase != 0)));
        chk("en",       32'(en),       32'(m_en));
        chk("addr",     32'(addr),     32'(m_addr));
        chk("data",     32'(data),     32'(m_data));
    end

    // ------------------------------------------------------------------------
    // Write-stage model: 0 idle, 1 request seen, 2 processing (ready low),
    // 3 done (ready high, waiting for en to drop).
    // ------------------------------------------------------------------------
    int          ws_state  = 0;
    int          ws_cnt    = 0;
    int          ws_len    = 4;
    bit          ws_hold   = 1'b0;
    bit          ws_rand   = 1'b0;
    int          ws_writes = 0;
    logic [28:0] ws_log[$];
    logic [20:0] ws_addr   = '0;
    logic [7:0]  ws_data   = '0;
    int          low_len   = 0;
    bit          b2b       = 1'b0;
    logic [28:0] exp_e;

    initial forever begin
        @(posedge clk_memory);
        #1;
        if (reset) begin
            ws_state = 0;
            ready    = 1'b1;
            low_len  = 0;
            b2b      = 1'b0;
        end else begin
            case (ws_state)
                0: begin
                    if (en) begin
                        ws_addr = addr;
                        ws_data = data;
                        ws_log.push_back({addr, data});
                        ws_writes++;
                        if (m_issued.size() == 0) begin
                            chk("ws_unexpected_write", 32'(1), 32'(0));
                        end else begin
                            exp_e = m_issued.pop_front();
                            chk("ws_order", 32'({addr, data}), 32'(exp_e));
                        end
                        if (b2b) chk("release_gap", 32'(low_len), 32'(2));
                        b2b      = 1'b0;
                        ws_state = 1;
                    end else begin
                        low_len++;
                    end
                end
                1: begin
                    chk("ws_en_accept", 32'(en), 32'(1));
                    ready    = 1'b0;
                    ws_cnt   = ws_rand ? int'($urandom_range(1, 5)) : ws_len;
                    ws_state = 2;
                end
                2: begin
                    chk("ws_en_busy",  32'(en),   32'(1));
                    chk("ws_addr_stable", 32'(addr), 32'(ws_addr));
                    chk("ws_data_stable", 32'(data), 32'(ws_data));
                    if (!ws_hold) begin
                        ws_cnt--;
                        if (ws_cnt == 0) begin
                            ready    = 1'b1;
                            ws_state = 3;
                        end
                    end
                end
                default: begin
                    chk("ws_en_done", 32'(en), 32'(0));
                    b2b      = (m_q.size() != 0);
                    low_len  = 1;
                    ws_state = 0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(negedge clk_memory);
    endtask

    task automatic push(input logic [20:0] a, input logic [7:0] d);
        in_we   = 1'b1;
        in_addr = a;
        in_data = d;
        tick();
        in_we   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int g = 0; g < 800 && pending; g++) tick();
        chk(name, 32'(pending), 32'(0));
    endtask

    task automatic wait_en();
        for (int g = 0; g < 10 && !en; g++) tick();
        chk("en_rise", 32'(en), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int base;
    int base_acc;
    bit found;

    initial begin
        // Reset held for 2 cycles with a push strobe active.
        tick();
        tick();
        reset = 1'b0;
        in_we = 1'b0;
        chk("rst_count",   32'(count),    32'(0));
        chk("rst_empty",   32'(empty),    32'(1));
        chk("rst_en",      32'(en),       32'(0));
        chk("rst_ovf",     32'(overflow), 32'(0));
        chk("rst_pending", 32'(pending),  32'(0));
        repeat (2) tick();

        // Single write: fixed 4-cycle busy time in the write stage.
        push(21'h12345, 8'hA5);
        chk("sw_empty", 32'(empty), 32'(0));
        chk("sw_en_e0", 32'(en),    32'(0));
        tick();
        chk("sw_en_e1", 32'(en),    32'(1));
        chk("sw_addr",  32'(addr),  32'h12345);
        chk("sw_data",  32'(data),  32'hA5);
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("sw_en_hold", 32'(en), 32'(1));
        end
        tick();
        chk("sw_en_fall",   32'(en),      32'(0));
        chk("sw_pend_rel",  32'(pending), 32'(1));
        tick();
        chk("sw_pend_fall", 32'(pending), 32'(0));
        chk("sw_writes",    32'(ws_writes), 32'(1));
        chk("sw_logged",    32'(ws_log[0]), 32'({21'h12345, 8'hA5}));
        repeat (3) tick();

        // Fill: sequencer stalled on a blocker, then 17 pushes into 16 slots.
        base    = ws_log.size();
        ws_hold = 1'b1;
        push(21'h00EEE, 8'hEE);
        wait_en();
        for (int i = 0; i < 17; i++) begin
            push(21'($urandom_range(0, 21'h1FFFFF)), 8'(i));
            if (i == 15) begin
                chk("fill_full16",  32'(full),     32'(1));
                chk("fill_ovf16",   32'(overflow), 32'(0));
            end
        end
        chk("fill_full17",  32'(full),     32'(1));
        chk("fill_ovf17",   32'(overflow), 32'(1));
        chk("fill_count",   32'(count),    32'(16));
        repeat (20) tick();
        chk("fill_stall_en", 32'(en), 32'(1));
        ws_hold = 1'b0;
        drain("fill_drain");
        chk("fill_nwrites", 32'(ws_log.size() - base), 32'(17));
        for (int i = 0; i < 17 && (base + i) < ws_log.size(); i++) begin
            chk("fill_order", 32'(ws_log[base + i][7:0]), (i == 0) ? 32'hEE : 32'(i - 1));
        end
        chk("fill_ovf_sticky", 32'(overflow), 32'(1));

        // Reset mid-BUSY with 5 entries queued (overflow still set).
        ws_hold = 1'b1;
        for (int i = 0; i < 6; i++) push(21'(21'h100 + i), 8'(8'h80 + i));
        for (int g = 0; g < 10 && m_phase != 2; g++) tick();
        chk("mb_en",    32'(en),    32'(1));
        chk("mb_count", 32'(count), 32'(5));
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        ws_hold = 1'b0;
        chk("mb_rst_en",    32'(en),       32'(0));
        chk("mb_rst_count", 32'(count),    32'(0));
        chk("mb_rst_ovf",   32'(overflow), 32'(0));
        base = ws_writes;
        repeat (20) tick();
        chk("mb_no_writes", 32'(ws_writes), 32'(base));

        // Push coinciding with the IDLE->ISSUE pop at count=3.
        ws_hold = 1'b1;
        push(21'h00055, 8'h55);
        wait_en();
        for (int i = 0; i < 3; i++) push(21'(21'h200 + i), 8'(8'h60 + i));
        ws_hold = 1'b0;
        found   = 1'b0;
        for (int g = 0; g < 60 && !found; g++) begin
            if (m_phase == 0 && m_q.size() == 3) begin
                push(21'h00270, 8'h70);
                found = 1'b1;
                chk("simul_count", 32'(count), 32'(3));
                chk("simul_en",    32'(en),    32'(1));
                chk("simul_data",  32'(data),  32'h60);
            end else begin
                tick();
            end
        end
        chk("simul_found", 32'(found), 32'(1));
        drain("simul_drain");

        // Randomized traffic: 40 pushes with random gaps and busy times.
        ws_rand  = 1'b1;
        base     = ws_writes;
        base_acc = m_accepts;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 10)) tick();
            push(21'($urandom_range(0, 21'h1FFFFF)), 8'($urandom_range(0, 255)));
        end
        drain("rand_drain");
        chk("rand_nwrites", 32'(ws_writes - base), 32'(m_accepts - base_acc));
        chk("rand_empty",   32'(empty), 32'(1));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
